// File: rtl/l2_mem_responder.sv
// Memory-side endpoint for the L2 arbiter: in-order single/burst reads and writes
// served from a word-addressed, byte-enabled single-port synchronous RAM.
module l2_mem_responder #(
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int ID_W            = 4,
    parameter int BURST_W         = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               request_valid,
    output logic               request_pop,
    input  logic [29:0]        addr,
    input  logic               rnw,
    input  logic               is_amo,
    input  logic [BURST_W-1:0] amo_type_or_burst_size,
    input  logic [ID_W-1:0]    id,
    input  logic               abort_request,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_data_be,
    input  logic               wr_data_valid,
    output logic               wr_data_read,
    output logic [31:0]        rd_data,
    output logic [ID_W-1:0]    rd_id,
    output logic               rd_data_valid,
    output logic               amo_drop
);
    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t             state;
    logic [AW-1:0]      cur_addr;
    logic [BURST_W-1:0] beats_left;
    logic [ID_W-1:0]    cur_id;
    logic               abort_seen;
    logic [31:0]        ram_q;
    logic [31:0]        mem [MEM_DEPTH_WORDS];

    logic is_lr;
    logic unused_bits;

    assign is_lr = is_amo && (amo_type_or_burst_size == BURST_W'(2));

    // Handshakes are combinational so a request/beat is taken in the cycle it is offered.
    assign request_pop  = rst && (state == IDLE) && request_valid;
    assign wr_data_read = rst && (state == WRITE) && wr_data_valid;
    assign rd_data      = rd_data_valid ? ram_q : 32'h0;

    // Upper address bits alias; abort is kept only as status.
    assign unused_bits = ^{addr[29:AW], abort_seen};

    always_ff @(posedge clk) begin
        if (wr_data_read) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_data_be[b]) mem[cur_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (state == READ) ram_q <= mem[cur_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            beats_left    <= '0;
            cur_id        <= '0;
            abort_seen    <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_id         <= '0;
            amo_drop      <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            amo_drop      <= 1'b0;
            case (state)
                IDLE: begin
                    if (request_valid) begin
                        cur_addr   <= addr[AW-1:0];
                        cur_id     <= id;
                        beats_left <= is_amo ? '0 : amo_type_or_burst_size;
                        abort_seen <= abort_request;
                        if ((rnw && !is_amo) || is_lr) state <= READ;
                        else if (!is_amo)              state <= WRITE;
                        else                           amo_drop <= 1'b1;
                    end
                end
                READ: begin
                    rd_data_valid <= 1'b1;
                    rd_id         <= cur_id;
                    cur_addr      <= cur_addr + AW'(1);
                    if (beats_left == '0) state <= IDLE;
                    else                  beats_left <= beats_left - BURST_W'(1);
                end
                WRITE: begin
                    if (wr_data_valid) begin
                        cur_addr <= cur_addr + AW'(1);
                        if (beats_left == '0) state <= IDLE;
                        else                  beats_left <= beats_left - BURST_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: reads push expected beats (data, id, cycle)
// from a flat memory model; an independent monitor pops and compares each beat.
module tb_l2_mem_responder;
    localparam int DEPTH = 16;
    localparam int AWT   = $clog2(DEPTH);
    localparam int IDW   = 4;
    localparam int BW    = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           request_valid = 1'b0;
    logic           request_pop;
    logic [29:0]    addr = '0;
    logic           rnw = 1'b0;
    logic           is_amo = 1'b0;
    logic [BW-1:0]  amo_type_or_burst_size = '0;
    logic [IDW-1:0] id = '0;
    logic           abort_request = 1'b0;
    logic [31:0]    wr_data = '0;
    logic [3:0]     wr_data_be = '0;
    logic           wr_data_valid = 1'b0;
    logic           wr_data_read;
    logic [31:0]    rd_data;
    logic [IDW-1:0] rd_id;
    logic           rd_data_valid;
    logic           amo_drop;

    l2_mem_responder #(.MEM_DEPTH_WORDS(DEPTH), .ID_W(IDW), .BURST_W(BW)) dut (
        .clk(clk), .rst(rst), .request_valid(request_valid), .request_pop(request_pop),
        .addr(addr), .rnw(rnw), .is_amo(is_amo), .amo_type_or_burst_size(amo_type_or_burst_size),
        .id(id), .abort_request(abort_request), .wr_data(wr_data), .wr_data_be(wr_data_be),
        .wr_data_valid(wr_data_valid), .wr_data_read(wr_data_read), .rd_data(rd_data),
        .rd_id(rd_id), .rd_data_valid(rd_data_valid), .amo_drop(amo_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]    data;
        logic [IDW-1:0] id;
        int             cyc;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] model [DEPTH];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int last_pop = 0;
    int drops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (amo_drop) drops++;
        if (rd_data_valid) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_id", 32'(rd_id), 32'(e.id));
                chk("beat_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic present(input logic [29:0] a, input logic r, input logic amo,
                           input logic [BW-1:0] f, input logic [IDW-1:0] i);
        int n;
        int nb;
        @(negedge clk);
        addr = a; rnw = r; is_amo = amo; amo_type_or_burst_size = f; id = i;
        abort_request = 1'($urandom_range(0, 1));
        request_valid = 1'b1;
        #1;
        n = 0;
        while (!request_pop && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!request_pop) chk("pop_timeout", 32'd0, 32'd1);
        last_pop = cyc;
        if ((r && !amo) || (amo && f == BW'(2))) begin
            nb = amo ? 1 : int'(f) + 1;
            for (int k = 0; k < nb; k++)
                exp_q.push_back('{model[(int'(a[AWT-1:0]) + k) % DEPTH], i, cyc + 2 + k});
        end
        @(posedge clk); #1;
        request_valid = 1'b0;
    endtask

    task automatic beats(input logic [29:0] a, input int f, input bit stall, input bit rnd,
                         input logic [31:0] dval, input logic [3:0] bval);
        logic [31:0] d;
        logic [3:0]  b;
        int          idx;
        for (int k = 0; k <= f; k++) begin
            if (stall) begin
                @(negedge clk);
                wr_data_valid = 1'b0;
                #1 chk("no_read_when_invalid", 32'(wr_data_read), 32'd0);
            end
            @(negedge clk);
            d = rnd ? $urandom : dval + 32'(k);
            b = rnd ? 4'($urandom) : bval;
            wr_data = d; wr_data_be = b; wr_data_valid = 1'b1;
            #1 chk("wr_read_when_valid", 32'(wr_data_read), 32'd1);
            idx = (int'(a[AWT-1:0]) + k) % DEPTH;
            for (int j = 0; j < 4; j++)
                if (b[j]) model[idx][8*j +: 8] = d[8*j +: 8];
        end
        @(negedge clk);
        wr_data_valid = 1'b0;
    endtask

    task automatic write_req(input logic [29:0] a, input int f, input bit stall, input bit rnd,
                             input logic [31:0] dval, input logic [3:0] bval);
        present(a, 1'b0, 1'b0, BW'(f), IDW'($urandom));
        beats(a, f, stall, rnd, dval, bval);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int p_read;
        int d0;
        // Reset with a pending 16-beat write that initialises the whole RAM.
        request_valid = 1'b1; addr = '0; rnw = 1'b0; is_amo = 1'b0;
        amo_type_or_burst_size = BW'(DEPTH - 1);
        repeat (3) begin
            @(negedge clk);
            chk("reset_ctrl", 32'({request_pop, wr_data_read, rd_data_valid, amo_drop}), 32'd0);
            chk("reset_rd_data", rd_data, 32'd0);
            chk("reset_rd_id", 32'(rd_id), 32'd0);
        end
        rst = 1'b1;
        #1 chk("pop_after_reset", 32'(request_pop), 32'd1);
        @(posedge clk); #1;
        request_valid = 1'b0;
        beats(30'h0, DEPTH - 1, 1'b0, 1'b1, 32'h0, 4'h0);

        // Single write then read.
        write_req(30'h10, 0, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF);
        present(30'h10, 1'b1, 1'b0, '0, 4'd3);

        // Partial byte enables.
        write_req(30'h5, 0, 1'b0, 1'b0, 32'hAABBCCDD, 4'hF);
        write_req(30'h5, 0, 1'b0, 1'b0, 32'h11223344, 4'b0101);
        present(30'h5, 1'b1, 1'b0, '0, 4'd1);

        // Burst read, with the next request offered immediately behind it.
        write_req(30'h20, 7, 1'b0, 1'b0, 32'h0, 4'hF);
        present(30'h20, 1'b1, 1'b0, BW'(7), 4'd5);
        p_read = last_pop;
        write_req(30'h3, 0, 1'b0, 1'b1, 32'h0, 4'h0);
        chk("pop_gap_after_burst", last_pop - p_read, 32'd9);

        // Wrapping burst write with stalls, then reads across the wrap.
        write_req(30'd14, 3, 1'b1, 1'b1, 32'h0, 4'h0);
        present(30'h0, 1'b1, 1'b0, '0, 4'd2);
        present(30'd14, 1'b1, 1'b0, BW'(3), 4'd9);

        // Unsupported AMO with write data waiting: dropped, nothing consumed.
        drain();
        d0 = drops;
        @(negedge clk);
        wr_data_valid = 1'b1; wr_data = 32'hFFFFFFFF; wr_data_be = 4'hF;
        present(30'h2, 1'b0, 1'b1, BW'(1), 4'd4);
        repeat (3) begin
            @(negedge clk);
            chk("amo_no_wr_read", 32'(wr_data_read), 32'd0);
        end
        chk("amo_drop_pulses", drops - d0, 32'd1);
        wr_data_valid = 1'b0;

        // LR behaves as a single-beat read.
        present(30'h2, 1'b1, 1'b1, BW'(2), 4'd6);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                present(30'($urandom_range(0, 63)), 1'b1, 1'b0, BW'($urandom_range(0, 5)), IDW'($urandom));
            else
                write_req(30'($urandom_range(0, 63)), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                          1'b1, 32'h0, 4'h0);
        end
        drain();

        // Reset in the middle of an 8-beat read, right after beat 3.
        present(30'h4, 1'b1, 1'b0, BW'(7), 4'd8);
        while (cyc != last_pop + 5) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("valid_drops_in_reset", 32'(rd_data_valid), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // RAM survives reset.
        present(30'h0, 1'b1, 1'b0, BW'(DEPTH - 1), 4'd11);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
